// File: rtl/fifo_arb_pkg.sv
// +----------------------------------------------------------------------+
// | fifo_arb_pkg : shared types and constants for fifo_wr_arbiter        |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

  localparam int GNT_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick  : combinational round-robin search starting above last_winner|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_winner_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] index_o
);

  // Walk the candidates from furthest to nearest so the nearest one wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cidx;
    cand    = 0;
    cidx    = '0;
    valid_o = |req_i;
    index_o = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last_winner_i) + k) % NREQ;
      cidx = IDX_W'(cand);
      if (req_i[cidx]) begin
        index_o = cidx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | fifo_wr_arbiter : round-robin burst arbiter for a FIFO write port.   |
// | Optional FIFO_WR_ARB_STALL_CNT_EN adds an 8-bit saturating stall_cnt.|
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic                  fifo_we,
  output logic [WIDTH-1:0]      fifo_wdata,
  output logic [GNT_W-1:0]      gnt_id,
  output logic                  busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [7:0]            stall_cnt
`endif
);

  localparam int         IDX_W     = $clog2(NREQ);
  localparam logic [3:0] BEAT_LAST = 4'(MAX_BURST - 1);

  arb_state_e        state_q;
  logic [IDX_W-1:0]  gnt_q;
  logic [IDX_W-1:0]  last_q;
  logic [3:0]        beat_q;
  logic [3:0]        beat_d;
  logic              busy_q;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic              hold_req;
  logic [WIDTH-1:0]  slice [NREQ];

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i         (req),
    .last_winner_i (last_q),
    .valid_o       (pick_valid),
    .index_o       (pick_idx)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = data[i*WIDTH +: WIDTH];
  end

  assign hold_req   = req[gnt_q];
  assign fifo_we    = busy_q & hold_req & ~fifo_full;
  assign fifo_wdata = slice[gnt_q];
  assign beat_d     = beat_q + 4'd1;
  assign busy       = busy_q;
  assign gnt_id     = GNT_W'(gnt_q);

  always_comb begin
    ack = '0;
    if (fifo_we) begin
      ack[gnt_q] = 1'b1;
    end
  end

  // A stalled grant (fifo_full) neither counts a beat nor times out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q <= GRANT;
            busy_q  <= 1'b1;
            gnt_q   <= pick_idx;
            last_q  <= pick_idx;
            beat_q  <= '0;
          end
        end
        GRANT: begin
          if (fifo_we) begin
            beat_q <= beat_d;
          end
          if (!hold_req || (fifo_we && (beat_q == BEAT_LAST))) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [7:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (busy_q && hold_req && fifo_full && (stall_q != 8'hFF)) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_fifo_wr_arbiter : directed scenarios plus randomized model check  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 3;
  localparam int MAX_BURST = 4;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full;
  logic                  fifo_we;
  logic [WIDTH-1:0]      fifo_wdata;
  logic [2:0]            gnt_id;
  logic                  busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [7:0]            stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data       (data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_we    (fifo_we),
    .fifo_wdata (fifo_wdata),
    .gnt_id     (gnt_id),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    data      = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req       = 4'hF;
    fifo_full = 1'b0;
    data      = '0;
    next_cycle();
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++;
    if (fifo_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", fifo_we); end
    checks++;
    if (ack !== 4'h0) begin errors++; $display("FAIL rst_ack got %0h exp 0", ack); end
    checks++;
    if (gnt_id !== 3'd0) begin errors++; $display("FAIL rst_gnt got %0d exp 0", gnt_id); end
    checks++;
    rst_n = 1'b1;
    #1;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %0b exp 0", busy); end
    checks++;
    next_cycle();
    if (busy !== 1'b1 || gnt_id !== 3'd0) begin
      errors++; $display("FAIL rst_first_grant got busy=%0b gnt=%0d exp busy=1 gnt=0", busy, gnt_id);
    end
    checks++;
    if (fifo_we !== 1'b1 || ack !== 4'b0001) begin
      errors++; $display("FAIL rst_first_word got we=%0b ack=%0h exp we=1 ack=1", fifo_we, ack);
    end
    checks++;
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] words [3];
    int n;
    logic exp_we, exp_busy;
    words[0] = 3'd5; words[1] = 3'd6; words[2] = 3'd7;
    do_reset();
    n = 0;
    for (int c = 0; c <= 6; c++) begin
      req[2] = (n < 3);
      set_data(2, (n < 3) ? words[n] : 3'd0);
      #1;
      exp_we   = (c >= 1 && c <= 3);
      exp_busy = (c >= 1 && c <= 4);
      if (fifo_we !== exp_we) begin errors++; $display("FAIL single_we c=%0d got %0b exp %0b", c, fifo_we, exp_we); end
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL single_busy c=%0d got %0b exp %0b", c, busy, exp_busy); end
      checks++;
      if (ack !== (exp_we ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL single_ack c=%0d got %0h exp %0h", c, ack, exp_we ? 4'b0100 : 4'b0000);
      end
      checks++;
      if (exp_we) begin
        if (fifo_wdata !== words[c-1]) begin
          errors++; $display("FAIL single_wdata c=%0d got %0d exp %0d", c, fifo_wdata, words[c-1]);
        end
        checks++;
        n++;
      end
      next_cycle();
    end
  endtask

  task automatic test_fairness();
    int grants[$];
    int words[$];
    int gaps[$];
    int idle_run;
    logic prev_busy;
    do_reset();
    req  = 4'hF;
    data = {3'd3, 3'd2, 3'd1, 3'd0};
    prev_busy = 1'b0;
    idle_run  = 0;
    for (int c = 0; c <= 25; c++) begin
      #1;
      if (busy && !prev_busy) begin
        if (grants.size() > 0) gaps.push_back(idle_run);
        grants.push_back(int'(gnt_id));
        words.push_back(0);
      end
      if (busy) idle_run = 0; else idle_run++;
      if (fifo_we) begin
        words[$] = words[$] + 1;
        if (int'(fifo_wdata) !== (grants.size() - 1) % NREQ) begin
          errors++; $display("FAIL fair_wdata c=%0d got %0d exp %0d", c, fifo_wdata, (grants.size() - 1) % NREQ);
        end
        checks++;
      end
      prev_busy = busy;
      next_cycle();
    end
    if (grants.size() !== 5) begin errors++; $display("FAIL fair_count got %0d exp 5", grants.size()); end
    checks++;
    for (int k = 0; k < grants.size() && k < 5; k++) begin
      if (grants[k] !== k % NREQ) begin errors++; $display("FAIL fair_order k=%0d got %0d exp %0d", k, grants[k], k % NREQ); end
      checks++;
      if (words[k] !== MAX_BURST) begin errors++; $display("FAIL fair_words k=%0d got %0d exp %0d", k, words[k], MAX_BURST); end
      checks++;
    end
    foreach (gaps[k]) begin
      if (gaps[k] !== 1) begin errors++; $display("FAIL fair_gap k=%0d got %0d exp 1", k, gaps[k]); end
      checks++;
    end
  endtask

  task automatic test_full_stall();
    logic exp_we, exp_busy;
    logic [WIDTH-1:0] d;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c <= 10; c++) begin
      fifo_full = (c >= 3 && c <= 7);
      d = WIDTH'($urandom_range(0, 7));
      set_data(0, d);
      #1;
      exp_we   = (c == 1 || c == 2 || c == 8 || c == 9);
      exp_busy = (c >= 1 && c <= 9);
      if (fifo_we !== exp_we) begin errors++; $display("FAIL stall_we c=%0d got %0b exp %0b", c, fifo_we, exp_we); end
      checks++;
      if (ack !== (exp_we ? 4'b0001 : 4'b0000)) begin errors++; $display("FAIL stall_ack c=%0d got %0h exp %0b", c, ack, exp_we); end
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL stall_busy c=%0d got %0b exp %0b", c, busy, exp_busy); end
      checks++;
      if (exp_we) begin
        if (fifo_wdata !== d) begin errors++; $display("FAIL stall_wdata c=%0d got %0d exp %0d", c, fifo_wdata, d); end
        checks++;
      end
      next_cycle();
    end
    fifo_full = 1'b0;
  endtask

  task automatic test_early_drop();
    logic [NREQ-1:0] req_tab  [5];
    logic            busy_tab [5];
    logic [NREQ-1:0] ack_tab  [5];
    req_tab  = '{4'b1010, 4'b1010, 4'b1001, 4'b1001, 4'b1001};
    busy_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ack_tab  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000};
    do_reset();
    for (int c = 0; c < 5; c++) begin
      req = req_tab[c];
      #1;
      if (busy !== busy_tab[c]) begin errors++; $display("FAIL drop_busy c=%0d got %0b exp %0b", c, busy, busy_tab[c]); end
      checks++;
      if (ack !== ack_tab[c]) begin errors++; $display("FAIL drop_ack c=%0d got %0h exp %0h", c, ack, ack_tab[c]); end
      checks++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100;
    set_data(2, 3'd4);
    next_cycle();
    next_cycle();
    #1;
    if (fifo_we !== 1'b1 || ack !== 4'b0100) begin
      errors++; $display("FAIL rmid_pre got we=%0b ack=%0h exp we=1 ack=4", fifo_we, ack);
    end
    checks++;
    rst_n = 1'b0;
    #1;
    if (fifo_we !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_async got we=%0b ack=%0h busy=%0b exp 0 0 0", fifo_we, ack, busy);
    end
    checks++;
    req = 4'b1010;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got %0b exp 0", busy); end
    checks++;
    next_cycle();
    if (busy !== 1'b1 || gnt_id !== 3'd1 || ack !== 4'b0010) begin
      errors++; $display("FAIL rmid_regrant got busy=%0b gnt=%0d ack=%0h exp 1 1 2", busy, gnt_id, ack);
    end
    checks++;
  endtask

  task automatic test_random();
    bit              m_busy;
    int              m_gnt, m_last, m_beats;
    logic            e_we;
    logic [NREQ-1:0] e_ack;
    logic [WIDTH-1:0] e_wdata;
    do_reset();
    m_busy = 0; m_gnt = 0; m_last = NREQ - 1; m_beats = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      e_we    = m_busy && req[m_gnt] && !fifo_full;
      e_ack   = e_we ? (NREQ'(1) << m_gnt) : '0;
      e_wdata = data[m_gnt*WIDTH +: WIDTH];
      if (fifo_we !== e_we) begin errors++; $display("FAIL rnd_we cyc=%0d got %0b exp %0b", cyc, fifo_we, e_we); end
      checks++;
      if (ack !== e_ack) begin errors++; $display("FAIL rnd_ack cyc=%0d got %0h exp %0h", cyc, ack, e_ack); end
      checks++;
      if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got %0b exp %0b", cyc, busy, m_busy); end
      checks++;
      if (m_busy) begin
        if (int'(gnt_id) !== m_gnt) begin errors++; $display("FAIL rnd_gnt cyc=%0d got %0d exp %0d", cyc, gnt_id, m_gnt); end
        checks++;
      end
      if (e_we) begin
        if (fifo_wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata cyc=%0d got %0d exp %0d", cyc, fifo_wdata, e_wdata); end
        checks++;
      end
      // Reference: round-robin holder serves up to MAX_BURST words, then leaves.
      if (!m_busy) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (!m_busy && req[(m_last + k) % NREQ]) begin
            m_busy  = 1;
            m_gnt   = (m_last + k) % NREQ;
            m_beats = 0;
          end
        end
        if (m_busy) m_last = m_gnt;
      end else begin
        if (e_we) m_beats++;
        if (!req[m_gnt] || m_beats == MAX_BURST) m_busy = 0;
      end
      next_cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (e_ack[i]) begin
          req[i] = ($urandom_range(0, 1) == 0);
          set_data(i, WIDTH'($urandom_range(0, 7)));
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_data(i, WIDTH'($urandom_range(0, 7)));
        end
      end
    end
    fifo_full = 1'b0;
  endtask

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    #1;
    if (stall_cnt !== 8'd0) begin errors++; $display("FAIL scnt_reset got %0d exp 0", stall_cnt); end
    checks++;
    req       = 4'b0001;
    fifo_full = 1'b1;
    for (int c = 0; c <= 301; c++) begin
      #1;
      if (c == 101) begin
        if (stall_cnt !== 8'd100) begin errors++; $display("FAIL scnt_mid got %0d exp 100", stall_cnt); end
        checks++;
      end
      next_cycle();
    end
    #1;
    if (stall_cnt !== 8'd255) begin errors++; $display("FAIL scnt_sat got %0d exp 255", stall_cnt); end
    checks++;
    fifo_full = 1'b0;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    data      = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_full_stall();
    test_early_drop();
    test_reset_mid();
    test_random();
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-002 Parameter WIDTH, default 3: data word width, matching the FIFO write port.
REQ-003 Parameter MAX_BURST, default 4: maximum words accepted per grant, 1..15.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 Ports:
- clk  input  1  single clock, also drives the FIFO wclk.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester write request, level, held until acked.
- data  input  NREQ*WIDTH  per-requester word; slice i belongs to req[i].
- ack  output  NREQ  one-cycle pulse per accepted word.
- fifo_full  input  1  FIFO full flag, in the clk domain.
- fifo_we  output  1  FIFO write enable.
- fifo_wdata  output  WIDTH  FIFO write data.
- gnt_id  output  3  index of the current grant holder; valid only while busy.
- busy  output  1  high while in state GRANT.

Function
REQ-006 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-007 In IDLE with any req bit set, the block SHALL register a winner chosen round-robin, searching upward from last_winner+1 (mod NREQ), then enter GRANT next cycle.
REQ-008 In GRANT, fifo_we, fifo_wdata and ack[gnt_id] SHALL be combinational: fifo_we = req[gnt_id] & ~fifo_full; fifo_wdata = data slice gnt_id; ack[gnt_id] = fifo_we.
REQ-009 Latency: a req seen in IDLE with FIFO not full SHALL produce its first fifo_we exactly 1 cycle later.
REQ-010 A 4-bit beat counter SHALL clear on grant and increment on each accepted word.
REQ-011 GRANT SHALL exit to IDLE after the cycle in which the beat count reaches MAX_BURST, or in the first cycle req[gnt_id] is low.
REQ-012 fifo_full high SHALL stall the grant: no fifo_we, no ack, no beat counted, and no timeout; the grant is held.
REQ-013 last_winner SHALL update on grant entry, so a continuously requesting holder yields to other pending requesters after MAX_BURST words.
REQ-014 No ack SHALL ever be asserted to a requester other than gnt_id, and at most one ack bit SHALL be high per cycle.
REQ-015 fifo_we SHALL never be high while fifo_full is high.
REQ-016 gnt_id bits above clog2(NREQ) SHALL be 0.

Reset
REQ-017 On rst_n low, the block SHALL asynchronously enter: state IDLE, last_winner NREQ-1 (first grant goes to requester 0), beat count 0, gnt_id 0, busy 0, fifo_we 0, ack 0.
REQ-018 Reset mid-burst SHALL abandon the burst with no further ack; after deassertion the next grant follows REQ-017.

Configuration
REQ-019 Macro FIFO_WR_ARB_STALL_CNT_EN: when defined, a port stall_cnt (output, 8 bits) SHALL count cycles in GRANT with req[gnt_id] high and fifo_full high, saturating at 255 and reset to 0.
REQ-020 When FIFO_WR_ARB_STALL_CNT_EN is undefined, neither the port nor the counter SHALL exist; all other behaviour is identical.

Structure
REQ-021 Package fifo_arb_pkg SHALL hold the state enum type (IDLE, GRANT) and the localparam for the gnt_id width (3).
REQ-022 The round-robin priority search SHALL be one sub-module, rr_pick (inputs: req vector and last_winner; outputs: valid and index), which is purely combinational.

Verification
REQ-023 Single requester: req[2]=1 for 3 words, data 5,6,7, FIFO empty -> fifo_we on cycles 1-3 with wdata 5,6,7, ack[2] three pulses, then IDLE.
REQ-024 Fairness: all 4 req held high, MAX_BURST=4 -> grants in order 0,1,2,3,0, with 4 words each and one IDLE cycle between grants.
REQ-025 Full stall: fifo_full raised after word 2 of a burst for 5 cycles -> no fifo_we and no ack for those 5 cycles; words 3-4 follow; busy stays 1 throughout.
REQ-026 Early drop: req[1] falls after 1 word -> return to IDLE the next cycle; the next grant goes to the next pending requester above 1.
REQ-027 Reset mid-burst: rst_n pulsed low during word 2 -> ack and fifo_we go 0 immediately; the first grant after reset goes to the lowest pending requester.
REQ-028 With FIFO_WR_ARB_STALL_CNT_EN defined: 300 stalled cycles -> stall_cnt = 255.
